// File: rtl/ifq_pkg.sv
// Shared types and sizing helpers for the instruction fetch queue.
// Entry widths are fixed here so storage and interface agree everywhere.
package ifq_pkg;
    localparam int IFQ_DATA_W = 32;
    localparam int IFQ_PC_W   = 32;
    localparam int IFQ_DEPTH  = 4;

    typedef struct packed {
        logic [IFQ_PC_W-1:0]   pc;
        logic [IFQ_DATA_W-1:0] instr;
    } ifq_entry_t;

    function automatic int ifq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ifq_read_fifo_if.sv
// Fetch/dispatch bundle of the instruction fetch queue.
// Handshake: a push happens when wr_en & ~full, a pop when rd_en & rd_valid,
// both taken on the rising clk edge; flush overrides both in the same cycle.
interface ifq_read_fifo_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) ();
    logic                     flush;
    logic                     wr_en;
    logic [PC_W-1:0]          wr_pc;
    logic [DATA_W-1:0]        wr_data;
    logic                     full;
    logic                     rd_en;
    logic                     rd_valid;
    logic [PC_W-1:0]          rd_pc;
    logic [DATA_W-1:0]        rd_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, wr_en, wr_pc, wr_data, rd_en,
        input  full, rd_valid, rd_pc, rd_data, count
    );

    modport slave (
        input  flush, wr_en, wr_pc, wr_data, rd_en,
        output full, rd_valid, rd_pc, rd_data, count
    );
endinterface

// File: rtl/ifq_ptr_ctrl.sv
// Pointer and occupancy tracking for the fetch queue; qualifies push/pop
// and derives full/rd_valid from the registered count only.
module ifq_ptr_ctrl
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic                     push,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     rd_valid
);
    localparam int PTR_W = ifq_ptr_w(DEPTH);
    localparam int CNT_W = ifq_cnt_w(DEPTH);

    logic pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign rd_valid = (count != '0);
    // Flush suppresses both so that storage is untouched in the flush cycle.
    assign push     = wr_en & ~full & ~flush;
    assign pop      = rd_en & rd_valid & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ifq_read_fifo.sv
// Instruction fetch queue: circular entry storage with a first-word-fall-through
// read port; pointer/count bookkeeping lives in ifq_ptr_ctrl.
module ifq_read_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    ifq_read_fifo_if.slave bus
);
    logic                     push;
    logic [$clog2(DEPTH)-1:0] wr_ptr;
    logic [$clog2(DEPTH)-1:0] rd_ptr;

    ifq_entry_t mem [DEPTH];

    ifq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .wr_en    (bus.wr_en),
        .rd_en    (bus.rd_en),
        .push     (push),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (bus.count),
        .full     (bus.full),
        .rd_valid (bus.rd_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{pc: bus.wr_pc, instr: bus.wr_data};
        end
    end

    // Head is read straight from storage: no write-to-read bypass.
    assign bus.rd_pc   = mem[rd_ptr].pc;
    assign bus.rd_data = mem[rd_ptr].instr;
endmodule

// File: tb/tb_ifq_read_fifo.sv
// Self-checking bench for ifq_read_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_ifq_read_fifo;
  import ifq_pkg::*;

  localparam int DEPTH = IFQ_DEPTH;
  localparam int EW    = IFQ_PC_W + IFQ_DATA_W;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [EW-1:0] exp_q[$];

  ifq_read_fifo_if #(.DATA_W(IFQ_DATA_W), .PC_W(IFQ_PC_W), .DEPTH(DEPTH)) bus ();

  ifq_read_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: plain FIFO queue, updated on the same edge as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (bus.flush) begin
      exp_q.delete();
    end else begin
      int  sz;
      logic do_pop, do_push;
      sz      = exp_q.size();
      do_pop  = bus.rd_en && (sz != 0);
      do_push = bus.wr_en && (sz < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({bus.wr_pc, bus.wr_data});
    end
  end

  // monitor: sampled on the falling edge
  always @(negedge clk) begin
    chk("count", EW'(bus.count), EW'(exp_q.size()));
    chk("full", EW'(bus.full), EW'(exp_q.size() == DEPTH));
    chk("rd_valid", EW'(bus.rd_valid), EW'(exp_q.size() != 0));
    if (bus.rd_valid && exp_q.size() != 0)
      chk("head", {bus.rd_pc, bus.rd_data}, exp_q[0]);
  end

  // driver tasks
  task automatic drive(input logic f, input logic we, input logic [31:0] pc,
                       input logic [31:0] data, input logic re);
    @(posedge clk);
    #1;
    bus.flush   = f;
    bus.wr_en   = we;
    bus.wr_pc   = pc;
    bus.wr_data = data;
    bus.rd_en   = re;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] data);
    drive(1'b0, 1'b1, pc, data, 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_full", EW'(bus.full), EW'(0));
    chk("rst_valid", EW'(bus.rd_valid), EW'(0));
    chk("rst_count", EW'(bus.count), EW'(0));
    chk("rst_rd_pc", EW'(bus.rd_pc), EW'(0));
    chk("rst_rd_data", EW'(bus.rd_data), EW'(0));
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_pc   = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // fill, overflow attempt, drain
    for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'(8'h11 * (i + 1)));
    push_one(32'h10, 32'h55);
    for (int i = 0; i < 4; i++) pop_one();
    idle(2);

    // steady occupancy of 3 with simultaneous push/pop, wrapping pointers
    for (int i = 0; i < 3; i++) push_one(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) pop_one();
    idle(1);

    // full queue: push+pop together only pops
    for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
    drive(1'b0, 1'b1, 32'h3F0, 32'hCF, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) pop_one();
    idle(1);

    // flush beats push and pop; next push becomes head
    push_one(32'h400, 32'hD0);
    push_one(32'h404, 32'hD1);
    drive(1'b1, 1'b1, 32'h408, 32'hD2, 1'b1);
    idle(1);
    push_one(32'h500, 32'hE0);
    idle(1);
    pop_one();
    idle(1);

    // read on empty queue
    for (int i = 0; i < 3; i++) pop_one();
    idle(1);
    push_one(32'h600, 32'hF0);
    idle(1);

    // async reset between edges with data queued
    push_one(32'h604, 32'hF1);
    mid_cycle_reset();
    push_one(32'h700, 32'h77);
    idle(1);
    pop_one();
    idle(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
